// File: rtl/rank_regfile_2r1w_if.sv
// Bus bundle for rank_regfile_2r1w: clear-sweep control, the write port and
// the two read ports. master = client side, slave = register file.
interface rank_regfile_2r1w_if #(
  parameter int WIDTH  = 21,
  parameter int ADDR_W = 5
);
  logic              clear_start;
  logic              clear_busy;
  logic              we;
  logic              wr_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_b;
  logic              acc_sat;

  modport master (
    output clear_start, we, wr_acc, wr_addr, wr_data,
           re_a, raddr_a, re_b, raddr_b,
    input  clear_busy, rdata_a, rvalid_a, rdata_b, rvalid_b, acc_sat
  );

  modport slave (
    input  clear_start, we, wr_acc, wr_addr, wr_data,
           re_a, raddr_a, re_b, raddr_b,
    output clear_busy, rdata_a, rvalid_a, rdata_b, rvalid_b, acc_sat
  );
endinterface

// File: rtl/rank_regfile_2r1w.sv
// Rank register file: 2 synchronous read ports (latency 1), 1 write port with
// overwrite / accumulate, write-to-read bypass, and a one-entry-per-cycle
// clear sweep used between PageRank iterations.
// Optional: define RANK_REGFILE_SAT_ACC_EN to make accumulate saturate at
// all-ones and pulse acc_sat on a clamp; otherwise accumulate wraps.

// One read port: registers bypassed/stored data, zero when idle or sweeping.
module rank_regfile_rport #(
  parameter int WIDTH  = 21,
  parameter int ADDR_W = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_re,
  input  logic [ADDR_W-1:0]                   i_raddr,
  input  logic [(2**ADDR_W)-1:0][WIDTH-1:0]   i_rf,
  input  logic                                i_clr,
  input  logic                                i_wr_en,
  input  logic [ADDR_W-1:0]                   i_wr_addr,
  input  logic [WIDTH-1:0]                    i_wr_val,
  output logic [WIDTH-1:0]                    o_rdata,
  output logic                                o_rvalid
);
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  // Sweep forces zero; a same-cycle write to this address wins over storage.
  assign w_data = i_clr ? '0 :
                  (i_wr_en && (i_wr_addr == i_raddr)) ? i_wr_val : i_rf[i_raddr];

  // Read data/valid register; data is zeroed when the port is not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      r_rdata  <= i_re ? w_data : '0;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

module rank_regfile_2r1w #(
  parameter int WIDTH  = 21,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  rank_regfile_2r1w_if.slave bus
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int NUM_RDP = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                        r_state, w_state_nxt;
  logic [ADDR_W-1:0]             r_cnt, w_cnt_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]   r_rf;
  logic                          w_wr_en;
  logic                          w_clr;
  logic [WIDTH-1:0]              w_wr_val;

  logic [NUM_RDP-1:0]             w_re;
  logic [NUM_RDP-1:0][ADDR_W-1:0] w_raddr;
  logic [NUM_RDP-1:0][WIDTH-1:0]  w_rdata;
  logic [NUM_RDP-1:0]             w_rvalid;

  assign w_clr   = (r_state == CLEAR);
  assign w_wr_en = bus.we & ~w_clr;   // writes are silently dropped mid-sweep

`ifdef RANK_REGFILE_SAT_ACC_EN
  logic [WIDTH:0] w_sum;
  logic           w_sat;
  logic           r_acc_sat;

  assign w_sum    = {1'b0, r_rf[bus.wr_addr]} + {1'b0, bus.wr_data};
  assign w_sat    = bus.wr_acc & w_sum[WIDTH];
  assign w_wr_val = !bus.wr_acc ? bus.wr_data :
                    w_sat       ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  // One-cycle pulse on any accepted accumulate that clamped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc_sat <= 1'b0;
    else       r_acc_sat <= w_wr_en & w_sat;
  end

  assign bus.acc_sat = r_acc_sat;
`else
  logic [WIDTH-1:0] w_acc;

  assign w_acc       = r_rf[bus.wr_addr] + bus.wr_data;   // wraps mod 2**WIDTH
  assign w_wr_val    = bus.wr_acc ? w_acc : bus.wr_data;
  assign bus.acc_sat = 1'b0;
`endif

  // Sweep FSM state and entry counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a start in IDLE begins a sweep; last entry returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.clear_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.clear_busy = w_clr;

  // Storage: sweep zeroes one entry per cycle, otherwise the write port updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rf <= '0;
    else if (w_clr)   r_rf[r_cnt] <= '0;
    else if (w_wr_en) r_rf[bus.wr_addr] <= w_wr_val;
  end

  assign w_re    = {bus.re_b, bus.re_a};
  assign w_raddr = {bus.raddr_b, bus.raddr_a};

  genvar p;
  generate
    for (p = 0; p < NUM_RDP; p++) begin : g_rport
      rank_regfile_rport #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rport (
        .clk       (clk),
        .reset     (reset),
        .i_re      (w_re[p]),
        .i_raddr   (w_raddr[p]),
        .i_rf      (r_rf),
        .i_clr     (w_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_val  (w_wr_val),
        .o_rdata   (w_rdata[p]),
        .o_rvalid  (w_rvalid[p])
      );
    end
  endgenerate

  assign bus.rdata_a  = w_rdata[0];
  assign bus.rvalid_a = w_rvalid[0];
  assign bus.rdata_b  = w_rdata[1];
  assign bus.rvalid_b = w_rvalid[1];
endmodule

// File: tb/tb_rank_regfile_2r1w.sv
// Bench for rank_regfile_2r1w: directed vector table, fill/sweep sequences,
// and reset-mid-sweep. Read expectations queued at drive, checked after edge.
module tb_rank_regfile_2r1w;
  localparam int WIDTH  = 21;
  localparam int ADDR_W = 5;

`ifdef RANK_REGFILE_SAT_ACC_EN
  localparam logic [WIDTH-1:0] ACC0_EXP = 21'h1FFFFF;
  localparam logic             SAT0_EXP = 1'b1;
`else
  localparam logic [WIDTH-1:0] ACC0_EXP = 21'h000010;
  localparam logic             SAT0_EXP = 1'b0;
`endif

  typedef struct {
    logic              clr, we, acc;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic              rea;
    logic [ADDR_W-1:0] ra;
    logic              reb;
    logic [ADDR_W-1:0] rb;
    logic              eav;
    logic [WIDTH-1:0]  ead;
    logic              ebv;
    logic [WIDTH-1:0]  ebd;
    logic              esat;
  } vec_t;

  typedef struct {
    logic             av;
    logic [WIDTH-1:0] ad;
    logic             bv;
    logic [WIDTH-1:0] bd;
    logic             sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[13];

  rank_regfile_2r1w_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  rank_regfile_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic acc, input int wa, input logic [WIDTH-1:0] wd,
                              input logic rea, input int ra, input logic reb, input int rb,
                              input logic eav, input logic [WIDTH-1:0] ead,
                              input logic ebv, input logic [WIDTH-1:0] ebd, input logic esat);
    vec_t v;
    v.clr = 1'b0; v.we = we; v.acc = acc; v.wa = ADDR_W'(wa); v.wd = wd;
    v.rea = rea; v.ra = ADDR_W'(ra); v.reb = reb; v.rb = ADDR_W'(rb);
    v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd; v.esat = esat;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, '0, 0, 0, 0, 0, 0, '0, 0, '0, 0);
  endfunction

  // Drive one cycle, queue its expectation, check it after the edge.
  task automatic cyc(input vec_t v);
    exp_t e;
    bus.clear_start = v.clr; bus.we = v.we; bus.wr_acc = v.acc;
    bus.wr_addr = v.wa; bus.wr_data = v.wd;
    bus.re_a = v.rea; bus.raddr_a = v.ra; bus.re_b = v.reb; bus.raddr_b = v.rb;
    e.av = v.eav; e.ad = v.ead; e.bv = v.ebv; e.bd = v.ebd; e.sat = v.esat;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("rvalid_a", 32'(bus.rvalid_a), 32'(e.av));
    chk("rdata_a",  32'(bus.rdata_a),  32'(e.ad));
    chk("rvalid_b", 32'(bus.rvalid_b), 32'(e.bv));
    chk("rdata_b",  32'(bus.rdata_b),  32'(e.bd));
    chk("acc_sat",  32'(bus.acc_sat),  32'(e.sat));
    bus.clear_start = 1'b0; bus.we = 1'b0; bus.re_a = 1'b0; bus.re_b = 1'b0;
  endtask

  // Fill every entry with a nonzero value (addr+1).
  task automatic fill();
    for (int i = 0; i < 32; i++)
      cyc(mk(1, 0, i, WIDTH'(i + 1), 0, 0, 0, 0, 0, '0, 0, '0, 0));
  endtask

  // Read every entry on both ports, expecting zero.
  task automatic read_all_zero();
    for (int i = 0; i < 32; i++)
      cyc(mk(0, 0, 0, '0, 1, i, 1, 31 - i, 1, '0, 1, '0, 0));
  endtask

  // Start a sweep and count busy samples; optional mid-sweep write/read/restart.
  task automatic run_sweep(input bit inject, output int n);
    vec_t v;
    n = 0;
    v = idle(); v.clr = 1'b1;
    cyc(v);
    if (bus.clear_busy) n++;
    for (int k = 0; k < 40; k++) begin
      v = idle();
      if (inject && k == 3) begin v.we = 1'b1; v.wa = '0; v.wd = 21'h777; end
      if (inject && k == 5) begin
        v.rea = 1'b1; v.ra = 5'd20; v.reb = 1'b1; v.rb = 5'd20; v.eav = 1'b1; v.ebv = 1'b1;
      end
      if (inject && k == 8) v.clr = 1'b1;
      cyc(v);
      if (bus.clear_busy) n++;
    end
  endtask

  initial begin
    int n;
    vec_t v;
    tbl[0]  = mk(0, 0, 0,  '0,        1, 3,  1, 31, 1, '0,        1, '0,        0);
    tbl[1]  = mk(0, 0, 0,  '0,        0, 3,  1, 3,  0, '0,        1, '0,        0);
    tbl[2]  = mk(1, 0, 7,  21'h00055, 0, 0,  0, 0,  0, '0,        0, '0,        0);
    tbl[3]  = mk(1, 1, 7,  21'h00010, 1, 7,  0, 0,  1, 21'h00065, 0, '0,        0);
    tbl[4]  = mk(1, 1, 7,  21'h00010, 0, 0,  1, 7,  0, '0,        1, 21'h00075, 0);
    tbl[5]  = mk(1, 1, 7,  21'h00010, 0, 0,  0, 0,  0, '0,        0, '0,        0);
    tbl[6]  = mk(0, 0, 0,  '0,        1, 7,  0, 0,  1, 21'h00085, 0, '0,        0);
    tbl[7]  = mk(1, 0, 12, 21'h1ABCD, 1, 12, 1, 12, 1, 21'h1ABCD, 1, 21'h1ABCD, 0);
    tbl[8]  = mk(0, 0, 0,  '0,        1, 12, 1, 7,  1, 21'h1ABCD, 1, 21'h00085, 0);
    tbl[9]  = mk(1, 0, 0,  21'h1FFFF0, 0, 0, 0, 0,  0, '0,        0, '0,        0);
    tbl[10] = mk(1, 1, 0,  21'h00020, 1, 0,  0, 0,  1, ACC0_EXP,  0, '0,        SAT0_EXP);
    tbl[11] = mk(0, 0, 0,  '0,        1, 0,  1, 0,  1, ACC0_EXP,  1, ACC0_EXP,  0);
    tbl[12] = mk(1, 1, 1,  21'h00005, 1, 1,  0, 0,  1, 21'h00005, 0, '0,        0);

    bus.clear_start = 0; bus.we = 0; bus.wr_acc = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.re_a = 0; bus.raddr_a = '0; bus.re_b = 0; bus.raddr_b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rvalid_a", 32'(bus.rvalid_a), 0);
    chk("reset rdata_a",  32'(bus.rdata_a), 0);
    chk("reset busy",     32'(bus.clear_busy), 0);
    chk("reset acc_sat",  32'(bus.acc_sat), 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) cyc(tbl[i]);

    // Full sweep with dropped write, zero read and ignored restart.
    fill();
    run_sweep(1'b1, n);
    chk("sweep busy cycles", 32'(n), 32);
    read_all_zero();

    // Reset part-way through a sweep.
    fill();
    v = idle(); v.clr = 1'b1;
    cyc(v);
    for (int k = 0; k < 10; k++)
      cyc(mk(0, 0, 0, '0, 1, 25, 1, 30, 1, '0, 1, '0, 0));
    chk("pre-reset busy", 32'(bus.clear_busy), 1);
    reset = 1'b1;
    #1;
    chk("abort busy",     32'(bus.clear_busy), 0);
    chk("abort rvalid_a", 32'(bus.rvalid_a), 0);
    chk("abort rvalid_b", 32'(bus.rvalid_b), 0);
    chk("abort rdata_a",  32'(bus.rdata_a), 0);
    chk("abort acc_sat",  32'(bus.acc_sat), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    read_all_zero();
    run_sweep(1'b0, n);
    chk("post-reset sweep busy cycles", 32'(n), 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rank_regfile_2r1w.md
Name: rank_regfile_2r1w

Overview:
- Parametrised successor to the single-port rank register file. Provides two independent synchronous read ports, one write port with optional read-modify-write accumulate, write-to-read bypass, and a cycle-by-cycle clear sweep.
- Sits between the PageRank edge-walk engine (port A reads, accumulate writes) and the rank-update/normalise stage (port B reads).
- The clear sweep zeroes rank accumulators between iterations without asserting global reset.

Parameters:
- WIDTH, 21, data word width in bits.
- ADDR_W, 5, address width; number of entries is DEPTH = 2**ADDR_W (derived, not overridable).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clear_start  in  1  one-cycle request to start a clear sweep.
- clear_busy  out  1  high while the clear sweep runs.
- we  in  1  write enable.
- wr_acc  in  1  write mode: 0 = overwrite; 1 = accumulate, rf[wr_addr] <= rf[wr_addr] + wr_data.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data or addend.
- re_a  in  1  port A read enable.
- raddr_a  in  ADDR_W  port A read address.
- rdata_a  out  WIDTH  port A read data.
- rvalid_a  out  1  port A data valid.
- re_b  in  1  port B read enable.
- raddr_b  in  ADDR_W  port B read address.
- rdata_b  out  WIDTH  port B read data.
- rvalid_b  out  1  port B data valid.
- acc_sat  out  1  accumulate-saturated pulse; see Optional Feature.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All DEPTH entries <= 0.
  - rdata_a, rdata_b, rvalid_a, rvalid_b, clear_busy, acc_sat <= 0.
  - FSM <= IDLE; sweep counter <= 0.
- Reads (ports A and B identical and independent; latency 1):
  - At edge N with re_x = 1: rdata_x <= entry value, rvalid_x <= 1.
  - With re_x = 0: rdata_x <= 0, rvalid_x <= 0.
  - Both ports may read the same address in the same cycle.
- Write, overwrite mode (we = 1, wr_acc = 0): rf[wr_addr] <= wr_data.
- Write, accumulate mode (we = 1, wr_acc = 1):
  - rf[wr_addr] <= (rf[wr_addr] + wr_data) mod 2**WIDTH, computed from the pre-edge stored value in a single cycle.
  - Back-to-back accumulates to the same address on consecutive cycles must chain correctly.
- Bypass: a read in the same cycle as a write to the same address returns the new value (overwrite data or accumulate result), not the old one.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_start = 1. clear_busy rises the edge after clear_start; counter = 0.
  - CLEAR: each cycle rf[counter] <= 0, counter++. After entry DEPTH-1 is cleared, return to IDLE and drop clear_busy. clear_busy is high for exactly DEPTH cycles.
  - During CLEAR, writes (we) are dropped silently.
  - During CLEAR, reads are honoured: rvalid_x <= re_x, rdata_x <= 0.
  - clear_start while in CLEAR is ignored (no restart).
- Reset mid-sweep aborts to IDLE, with all entries zeroed by reset.

Optional Feature:
- Macro: RANK_REGFILE_SAT_ACC_EN.
- Defined:
  - Accumulate saturates at 2**WIDTH-1 instead of wrapping.
  - acc_sat <= 1 for one cycle on the edge where saturation clamps the result; 0 otherwise.
  - The bypass value on the read ports equals the clamped value.
- Undefined:
  - Accumulate wraps modulo 2**WIDTH.
  - acc_sat is constant 0.

Test Plan:
- Reset, then re_a = re_b = 1 at addresses 3 and 31 -> next cycle rdata_a = rdata_b = 0, rvalid_a = rvalid_b = 1; with re_a = 0 -> rdata_a = 0, rvalid_a = 0.
- Write 0x00055 to addr 7 (overwrite), then accumulate 0x00010 on three consecutive cycles to addr 7 -> port A read of 7 returns 0x00085.
- Same-cycle write 0x1ABCD to addr 12 with re_a = re_b = 1 at addr 12 -> both ports return 0x1ABCD next cycle (bypass); addr 12 holds 0x1ABCD afterwards.
- Accumulate: addr 0 = 0x1FFFF0, add 0x20:
  - Without macro -> addr 0 = 0x000010, acc_sat = 0.
  - With RANK_REGFILE_SAT_ACC_EN -> addr 0 = 0x1FFFFF, acc_sat pulses once.
- Fill all 32 entries nonzero, pulse clear_start:
  - clear_busy is high for exactly 32 cycles.
  - A we during the sweep is dropped; a read during the sweep returns 0 with rvalid = 1.
  - All entries read 0 afterwards.
  - A second clear_start mid-sweep does not extend busy.
- Assert reset at sweep cycle 10 -> clear_busy falls immediately, all outputs 0, all entries 0, FSM accepts a new clear_start after reset release.
